sha256_wb_queue: RTL and testbench
==================================

Name: sha256_wb_queue

Overview:
- Wishbone slave wrapping the existing sha256 core (ports clk, rst, init, next, block, digest, digest_valid, ready).
- Adds a parametrised queue of 512-bit message blocks and an autonomous sequencer that feeds queued blocks to the core with init/next. Software can stream multi-block messages without polling ready between blocks.
- Also adds a registered Wishbone ack, byte-lane writes, bus error, a block counter and a maskable completion interrupt.

Parameters:
- AW, 32, Wishbone address width; only wb_adr_i[7:2] is decoded.
- NBLK, 2, queue depth in blocks, 1..4. One further block may be in flight in the core.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wb_adr_i  in  AW  byte address
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte lane enables
- wb_we_i  in  1  write enable
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_dat_o  out  32  read data, registered
- wb_ack_o  out  1  access acknowledge
- wb_err_o  out  1  access error
- int_o  out  1  completion interrupt

Behaviour:
- Reset (async, active-high) clears everything: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, int_o=0; staging words, queue, counter, irq state; sequencer to IDLE. Core rst is driven by wb_rst_i.
- Access protocol:
  - req = wb_stb_i & wb_cyc_i & ~wb_ack_o & ~wb_err_o.
  - On the edge where req=1, exactly one of ack/err is asserted for one cycle. Writes commit and read data is registered on that same edge, so latency is 1 cycle.
  - Back-to-back accesses therefore take 2 cycles each.
- Register map by wb_adr_i[7:2]:
  - 0, CTRL write:
    - bit0 PUSH_FIRST, bit1 PUSH_NEXT: copy staging into queue tail, tagged first/next. Both set = FIRST.
    - bit4 IRQ_EN: stored.
    - bit8 IRQ_CLR: clears irq_pending.
    - bit31 FLUSH: empties queue; does not abort the in-flight block.
  - 0, STATUS read: bit0 core ready, bit1 digest_valid, bit2 queue full, bit3 queue empty, bit4 irq_pending, bit5 irq_en, bit6 busy (FSM not IDLE), bits[10:8] queue count.
  - 1..16: staging word k-1, R/W. Byte lanes honoured (sel[i] writes bits 8i+7:8i). Block mapping is {w15,...,w0}, so address 16 holds block[511:480], the first message word.
  - 17..24: digest[32(k-17)+31:32(k-17)], RO. Address 24 is the first hash word.
  - 25: BLKCNT, RO, 32 bit. Blocks completed since the last FIRST issued; wraps at 2^32.
  - Other addresses, or writes to 17..25: wb_err_o, no state change, read data 0.
- Push while queue full → wb_err_o; block dropped; FLUSH/IRQ bits of the same write still take effect.
- Sequencer FSM:
  - IDLE: if queue non-empty and core ready → load head into cur_block and pop. init if tagged first, else next. Go to ISSUE.
  - ISSUE: drive init or next high for exactly 1 cycle, cur_block held → WAIT_BUSY.
  - WAIT_BUSY: wait until ready=0 → WAIT_DONE.
  - WAIT_DONE: wait until ready=1. Then BLKCNT = (first ? 1 : BLKCNT+1). If queue empty, set irq_pending. → IDLE.
- cur_block stays stable from ISSUE until return to IDLE. Staging may be rewritten freely after any push.
- Push and pop in the same cycle: count unchanged, no error even if full.
- irq_pending set and IRQ_CLR in the same cycle: set wins. int_o = irq_pending & irq_en, registered.
- FLUSH during WAIT_*: in-flight block completes normally; irq sets on completion because the queue is empty.
- Reset mid-operation: all state cleared immediately; the core restarts from reset.

Test Plan:
- "abc" single block. addr16=0x61626380, addr1=0x00000018, rest 0. CTRL=0x11 (FIRST, IRQ_EN) → digest addr24=0xba7816bf, addr17=0xf20015ad; BLKCNT=1; int_o=1. Then CTRL=0x110 → int_o=0 next cycle.
- FIPS two-block "abcdbcdecdefdefg...nopq", both blocks pushed back-to-back (FIRST, NEXT) without polling → digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1 (addr24 down to addr17); BLKCNT=2; irq set only once, after block 2.
- NBLK=2, four pushes at 2-cycle spacing while the first block runs → pushes 1-3 acked; push 4 gives wb_err_o=1; STATUS bit2=1, count=2.
- Byte lanes: write 0xFFFFFFFF to addr1, then 0x12345678 with sel=4'b0101 → readback 0xFF34FF78.
- Bad access: read addr 30 → err=1, ack=0, data 0. Write addr 18 → err, digest unchanged. Each response is a 1-cycle pulse.
- Async reset asserted mid-block in WAIT_DONE, deasserted off-edge → ack/err/int_o low at once; STATUS=0x0000_0009 (ready, empty) once the core is ready; BLKCNT=0.

Source files
------------

// File: rtl/sha256_wb_queue.sv
// sha256_wb_queue: Wishbone slave around a SHA-256 core, with a queue of
// 512-bit message blocks and a sequencer that issues them to the core.
// Ports:
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   wb_adr_i           : byte address; bits [7:2] select a register
//   wb_dat_i, wb_sel_i : write data, byte lane enables
//   wb_we_i, wb_stb_i, wb_cyc_i : Wishbone request
//   wb_dat_o, wb_ack_o, wb_err_o : registered response (one-cycle latency)
//   int_o              : completion interrupt (irq_pending & irq_en)

// sha256: iterative SHA-256 compression core, one round per clock.
// Ports: clk, rst (async active-high), init/next start pulses, block in,
// digest out {H0..H7}, digest_valid, ready (idle).
module sha256 (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         next,
    input  logic [511:0] block,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         ready
);
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    logic [31:0] r_h [8];
    logic [31:0] r_v [8];   // working variables a..h
    logic [31:0] r_w [16];  // sliding message schedule window, r_w[0] = W[t]
    logic [6:0]  r_rnd;
    logic        r_busy;
    logic        r_valid;
    logic [31:0] w_t1, w_t2, w_wn;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    always_comb begin
        w_t1 = r_v[7] + (rotr(r_v[4], 6) ^ rotr(r_v[4], 11) ^ rotr(r_v[4], 25))
             + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6])) + K[r_rnd[5:0]] + r_w[0];
        w_t2 = (rotr(r_v[0], 2) ^ rotr(r_v[0], 13) ^ rotr(r_v[0], 22))
             + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
        w_wn = (rotr(r_w[14], 17) ^ rotr(r_w[14], 19) ^ (r_w[14] >> 10)) + r_w[9]
             + (rotr(r_w[1], 7) ^ rotr(r_w[1], 18) ^ (r_w[1] >> 3)) + r_w[0];
        for (int i = 0; i < 8; i++) digest[32*(7-i) +: 32] = r_h[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_h[i] <= '0;
                r_v[i] <= '0;
            end
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
            r_rnd   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else if (!r_busy) begin
            if (init || next) begin
                for (int i = 0; i < 8; i++) begin
                    r_h[i] <= init ? IV[i] : r_h[i];
                    r_v[i] <= init ? IV[i] : r_h[i];
                end
                for (int i = 0; i < 16; i++) r_w[i] <= block[32*(15-i) +: 32];
                r_rnd   <= '0;
                r_busy  <= 1'b1;
                r_valid <= 1'b0;
            end
        end else if (r_rnd == 7'd64) begin
            // all 64 rounds done: fold working variables into the hash state
            for (int i = 0; i < 8; i++) r_h[i] <= r_h[i] + r_v[i];
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
        end else begin
            r_v[0] <= w_t1 + w_t2;
            r_v[4] <= r_v[3] + w_t1;
            for (int i = 1; i < 8; i++) if (i != 4) r_v[i] <= r_v[i-1];
            for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
            r_w[15] <= w_wn;
            r_rnd   <= r_rnd + 7'd1;
        end
    end

    assign ready        = ~r_busy;
    assign digest_valid = r_valid;
endmodule

module sha256_wb_queue #(
    parameter int AW   = 32,
    parameter int NBLK = 2
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_stb_i,
    input  logic          wb_cyc_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          int_o
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    state_t       r_state, w_state_nxt;
    logic [31:0]  r_stage [16];
    logic [511:0] r_q_blk [4];      // sized for the largest NBLK so 2-bit indices fit
    logic [3:0]   r_q_first;
    logic [1:0]   r_head, r_tail;
    logic [2:0]   r_count;
    logic [511:0] r_cur_block;
    logic         r_cur_first;
    logic [31:0]  r_blkcnt, r_dat;
    logic         r_irq_pend, r_irq_en, r_int, r_ack, r_err;

    logic         w_core_ready, w_core_dvalid, w_core_init, w_core_next;
    logic [255:0] w_core_digest;
    logic [511:0] w_stage_blk;
    logic [31:0]  w_rdata;
    logic [5:0]   w_adr;
    logic [3:0]   w_sidx;
    logic [2:0]   w_didx;
    logic w_req, w_wr, w_is_ctrl, w_is_stage, w_is_dig, w_is_cnt, w_bad_adr;
    logic w_full, w_empty, w_pop, w_ctrl_wr, w_push_req, w_push_err, w_push;
    logic w_flush, w_err, w_ack, w_done;
    logic w_unused;

    function automatic logic [1:0] nxt_idx(input logic [1:0] i);
        return (i == 2'(NBLK - 1)) ? 2'd0 : i + 2'd1;
    endfunction

    assign w_unused   = &{1'b0, wb_adr_i[AW-1:8], wb_adr_i[1:0]};
    assign w_req      = wb_stb_i & wb_cyc_i & ~r_ack & ~r_err;
    assign w_wr       = w_req & wb_we_i;
    assign w_adr      = wb_adr_i[7:2];
    assign w_sidx     = w_adr[3:0] - 4'd1;   // address 16 wraps to word 15
    assign w_didx     = w_adr[2:0] - 3'd1;   // address 24 wraps to slice 7
    assign w_is_ctrl  = (w_adr == 6'd0);
    assign w_is_stage = (w_adr >= 6'd1) && (w_adr <= 6'd16);
    assign w_is_dig   = (w_adr >= 6'd17) && (w_adr <= 6'd24);
    assign w_is_cnt   = (w_adr == 6'd25);
    assign w_bad_adr  = wb_we_i ? ~(w_is_ctrl | w_is_stage)
                                : ~(w_is_ctrl | w_is_stage | w_is_dig | w_is_cnt);

    assign w_full     = (r_count == 3'(NBLK));
    assign w_empty    = (r_count == 3'd0);
    assign w_pop      = (r_state == S_IDLE) & ~w_empty & w_core_ready;
    assign w_ctrl_wr  = w_wr & w_is_ctrl;
    assign w_push_req = w_ctrl_wr & (wb_dat_i[0] | wb_dat_i[1]);
    // a pop in the same cycle frees a slot, so a full queue still accepts
    assign w_push_err = w_push_req & w_full & ~w_pop;
    assign w_push     = w_push_req & ~w_push_err;
    assign w_flush    = w_ctrl_wr & wb_dat_i[31];
    assign w_err      = w_req & (w_bad_adr | w_push_err);
    assign w_ack      = w_req & ~w_err;
    assign w_done     = (r_state == S_WAIT_DONE) & w_core_ready;

    always_comb begin
        for (int i = 0; i < 16; i++) w_stage_blk[32*i +: 32] = r_stage[i];
        w_rdata = '0;
        if (w_req && !wb_we_i && !w_bad_adr) begin
            if (w_is_ctrl)
                w_rdata = {21'd0, r_count, 1'b0, (r_state != S_IDLE), r_irq_en, r_irq_pend,
                           w_empty, w_full, w_core_dvalid, w_core_ready};
            else if (w_is_stage) w_rdata = r_stage[w_sidx];
            else if (w_is_dig)   w_rdata = w_core_digest[{w_didx, 5'b00000} +: 32];
            else                 w_rdata = r_blkcnt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_core_init = 1'b0;
        w_core_next = 1'b0;
        case (r_state)
            S_IDLE:      if (w_pop) w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                w_core_init = r_cur_first;
                w_core_next = ~r_cur_first;
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: if (!w_core_ready) w_state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (w_core_ready) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < 16; i++) r_stage[i] <= '0;
            for (int i = 0; i < 4; i++) r_q_blk[i] <= '0;
            r_q_first   <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_cur_block <= '0;
            r_cur_first <= 1'b0;
            r_blkcnt    <= '0;
            r_dat       <= '0;
            r_irq_pend  <= 1'b0;
            r_irq_en    <= 1'b0;
            r_int       <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ack <= w_ack;
            r_err <= w_err;
            r_int <= r_irq_pend & r_irq_en;
            if (w_req) r_dat <= w_rdata;

            if (w_wr && w_is_stage)
                for (int b = 0; b < 4; b++)
                    if (wb_sel_i[b]) r_stage[w_sidx][8*b +: 8] <= wb_dat_i[8*b +: 8];

            if (w_ctrl_wr) r_irq_en <= wb_dat_i[4];
            // completion sets pending even if software clears it in the same cycle
            if (w_done && w_empty)              r_irq_pend <= 1'b1;
            else if (w_ctrl_wr && wb_dat_i[8])  r_irq_pend <= 1'b0;

            if (w_done) r_blkcnt <= r_cur_first ? 32'd1 : r_blkcnt + 32'd1;

            if (w_pop) begin
                r_cur_block <= r_q_blk[r_head];
                r_cur_first <= r_q_first[r_head];
            end

            // flush discards queued blocks; a push in the same write lands in the emptied queue
            if (w_flush) begin
                r_head  <= 2'd0;
                r_tail  <= w_push ? 2'd1 : 2'd0;
                r_count <= w_push ? 3'd1 : 3'd0;
                if (w_push) begin
                    r_q_blk[0]   <= w_stage_blk;
                    r_q_first[0] <= wb_dat_i[0];
                end
            end else begin
                if (w_push) begin
                    r_q_blk[r_tail]   <= w_stage_blk;
                    r_q_first[r_tail] <= wb_dat_i[0];
                    r_tail            <= nxt_idx(r_tail);
                end
                if (w_pop) r_head <= nxt_idx(r_head);
                r_count <= r_count + 3'(w_push) - 3'(w_pop);
            end
        end
    end

    sha256 u_core (
        .clk          (wb_clk_i),
        .rst          (wb_rst_i),
        .init         (w_core_init),
        .next         (w_core_next),
        .block        (r_cur_block),
        .digest       (w_core_digest),
        .digest_valid (w_core_dvalid),
        .ready        (w_core_ready)
    );

    assign wb_dat_o = r_dat;
    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign int_o    = r_int;
endmodule

// File: tb/tb_sha256_wb_queue.sv
module tb_sha256_wb_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, dat_i, dat_o;
    logic [3:0]  sel;
    logic        we, stb, cyc, ack, err, irq;

    int total = 0;
    int bad   = 0;
    int rises = 0;
    logic irq_prev = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (irq && !irq_prev) rises++;
        irq_prev = irq;
    end

    sha256_wb_queue #(.AW(32), .NBLK(2)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_stb_i (stb),
        .wb_cyc_i (cyc),
        .wb_dat_o (dat_o),
        .wb_ack_o (ack),
        .wb_err_o (err),
        .int_o    (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic acc(input logic w, input int widx, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic a, output logic e);
        int n;
        @(negedge clk);
        adr = 32'(widx) << 2; dat_i = d; sel = s; we = w; stb = 1'b1; cyc = 1'b1;
        n = 0; a = 1'b0; e = 1'b0;
        while (!a && !e && n < 8) begin
            @(posedge clk); #1;
            a = ack; e = err; n++;
        end
        rd = dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (!a && !e) chk("response_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input int widx, input logic [31:0] d);
        logic [31:0] rd; logic a, e;
        acc(1'b1, widx, d, 4'hF, rd, a, e);
    endtask

    task automatic rdw(input int widx, output logic [31:0] rd);
        logic a, e;
        acc(1'b0, widx, 32'd0, 4'hF, rd, a, e);
    endtask

    task automatic rd_chk(input string tag, input int widx, input logic [31:0] exp);
        logic [31:0] rd;
        rdw(widx, rd);
        chk(tag, rd, exp);
    endtask

    // message word j (first word = block[511:480]) lives at address 16-j
    task automatic load_blk(input logic [511:0] blk);
        for (int j = 0; j < 16; j++) wr(16 - j, blk[32*(15-j) +: 32]);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int n;
        n = 0; s = '0;
        do begin
            rdw(0, s);
            n++;
        end while (((s & 32'h49) != 32'h09) && n < 400);
        chk(tag, s & 32'h49, 32'h09);
    endtask

    localparam logic [511:0] ABC  = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] BLK1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK2 = {480'd0, 32'h000001c0};

    logic [31:0] exp2 [8] = '{32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                              32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

    initial begin
        logic [31:0] rd, st;
        logic a, e;
        logic [3:0] pa, pe;

        rst = 1'b1; adr = '0; dat_i = '0; sel = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_int", {31'd0, irq}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        rd_chk("rst_status", 0, 32'h00000009);

        // "abc" single block with interrupt enabled
        load_blk(ABC);
        wr(0, 32'h11);
        @(posedge clk); #1;
        chk("ack_pulse", {31'd0, ack}, 32'd0);
        wait_idle("abc_idle");
        rd_chk("abc_h0", 24, 32'hba7816bf);
        rd_chk("abc_h7", 17, 32'hf20015ad);
        rd_chk("abc_blkcnt", 25, 32'd1);
        repeat (2) @(posedge clk); #1;
        chk("abc_int", {31'd0, irq}, 32'd1);
        wr(0, 32'h110);
        repeat (2) @(posedge clk); #1;
        chk("abc_int_clr", {31'd0, irq}, 32'd0);

        // bad accesses
        acc(1'b0, 30, 32'd0, 4'hF, rd, a, e);
        chk("bad_rd_err", {31'd0, e}, 32'd1);
        chk("bad_rd_ack", {31'd0, a}, 32'd0);
        chk("bad_rd_dat", rd, 32'd0);
        @(posedge clk); #1;
        chk("err_pulse", {31'd0, err}, 32'd0);
        acc(1'b1, 18, 32'hdeadbeef, 4'hF, rd, a, e);
        chk("bad_wr_err", {31'd0, e}, 32'd1);
        rd_chk("dig_unchanged", 18, 32'hb410ff61);

        // two-block message, second block pushed while the first runs
        rises = 0;
        load_blk(BLK1);
        wr(0, 32'h11);
        load_blk(BLK2);
        wr(0, 32'h12);
        wait_idle("two_idle");
        repeat (3) @(posedge clk);
        for (int k = 0; k < 8; k++) rd_chk($sformatf("two_h%0d", k), 24 - k, exp2[k]);
        rd_chk("two_blkcnt", 25, 32'd2);
        chk("two_irq_once", 32'(rises), 32'd1);
        chk("two_int", {31'd0, irq}, 32'd1);
        wr(0, 32'h110);

        // queue overflow with NBLK=2
        for (int p = 0; p < 4; p++) begin
            acc(1'b1, 0, 32'h01, 4'hF, rd, a, e);
            pa[p] = a; pe[p] = e;
        end
        chk("push_acks", {28'd0, pa}, 32'h7);
        chk("push_errs", {28'd0, pe}, 32'h8);
        rdw(0, st);
        chk("push_full", (st >> 2) & 32'h1, 32'd1);
        chk("push_count", (st >> 8) & 32'h7, 32'd2);
        wait_idle("push_idle");
        rd_chk("push_blkcnt", 25, 32'd1);

        // byte lanes
        wr(1, 32'hFFFFFFFF);
        acc(1'b1, 1, 32'h12345678, 4'b0101, rd, a, e);
        rd_chk("byte_lanes", 1, 32'hFF34FF78);

        // asynchronous reset in the middle of a block
        load_blk(ABC);
        wr(0, 32'h11);
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_ack", {31'd0, ack}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_int", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        rd_chk("mid_rst_status", 0, 32'h00000009);
        rd_chk("mid_rst_blkcnt", 25, 32'd0);
        rd_chk("mid_rst_stage", 16, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
